multicycle_controller: RTL and testbench

- Sequencing controller for the single-bus MIPS-subset datapath; replaces per-cycle combinational decode with a multi-cycle FSM.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives register-file, ALU, PC, IR and data-memory strobes.
- Handles ready-based handshakes to instruction and data memory, with a watchdog on both.
- Sits between the fetch unit / memories and the datapath.

---
 rtl/multicycle_controller_pkg.sv | 48 ++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller_class_decode.sv | 34 +++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle sequencing controller: opcode and
// funct constants, PC source encodings, FSM state encoding and the decoded
// instruction-class payload passed from the class decoder to the FSM.
package cu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_NORD  = 6'h15;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;
  localparam logic [OP_W-1:0] OP_SH    = 6'h29;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_JR = 6'h08;

  typedef enum logic [PCSRC_W-1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_REG    = 2'b10
  } pc_src_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Instruction class flags derived from the latched opcode/funct.
  typedef struct packed {
    logic is_rtype;
    logic is_jr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic reads_reg;
    logic writes_reg;
  } instr_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath/memory-side bundle of the controller.
//   master : controller view (takes decode fields + ready flags, drives strobes)
//   slave  : datapath/memory view (the opposite directions)
// OPCODE/FUNCT valid with I_READY; ZERO valid in EXEC; PC_SRC 00=PC+4,
// 01=branch target, 10=register (JR); ERR is the sticky watchdog fault.
interface multicycle_controller_if;

  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       ZERO;
  logic       I_READY;
  logic       M_READY;

  logic       I_REQ;
  logic       IR_WRITE;
  logic       PC_WRITE;
  logic [1:0] PC_SRC;
  logic       RG_READ;
  logic       RG_WRITE;
  logic       RG_DST;
  logic       ALU_EN;
  logic       BRANCH;
  logic       M_READ;
  logic       M_WRITE;
  logic       ERR;

  modport master (
    input  OPCODE, FUNCT, ZERO, I_READY, M_READY,
    output I_REQ, IR_WRITE, PC_WRITE, PC_SRC, RG_READ, RG_WRITE, RG_DST,
           ALU_EN, BRANCH, M_READ, M_WRITE, ERR
  );

  modport slave (
    output OPCODE, FUNCT, ZERO, I_READY, M_READY,
    input  I_REQ, IR_WRITE, PC_WRITE, PC_SRC, RG_READ, RG_WRITE, RG_DST,
           ALU_EN, BRANCH, M_READ, M_WRITE, ERR
  );

endinterface

// File: rtl/multicycle_controller_class_decode.sv
// Purely combinational instruction classifier.
//   opcode_i : latched instruction[31:26]
//   funct_i  : latched instruction[5:0]
//   cls_o    : class flags (R-type, JR, branch, load, store, reads/writes reg)
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic [FN_W-1:0] funct_i,
  output instr_class_t    cls_o
);

  logic rtype_c;
  logic jr_c;
  logic branch_c;
  logic load_c;
  logic store_c;

  assign rtype_c  = (opcode_i == OP_RTYPE);
  assign jr_c     = rtype_c && (funct_i == FN_JR);
  assign branch_c = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
  assign load_c   = (opcode_i == OP_LW);
  assign store_c  = (opcode_i == OP_SB) || (opcode_i == OP_SH) || (opcode_i == OP_SW);

  // Anything not otherwise classified is an I-type ALU op writing rt.
  assign cls_o.is_rtype   = rtype_c;
  assign cls_o.is_jr      = jr_c;
  assign cls_o.is_branch  = branch_c;
  assign cls_o.is_load    = load_c;
  assign cls_o.is_store   = store_c;
  assign cls_o.reads_reg  = (opcode_i != OP_NORD);
  assign cls_o.writes_reg = !(jr_c || branch_c || store_c);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-bus datapath.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset; forces every strobe low at once
//   bus   : master side of multicycle_controller_if (decode fields, ZERO,
//           I_READY/M_READY in; fetch, PC, IR, regfile, ALU, memory strobes
//           and sticky ERR out)
// Strobes are decoded from the state register and the latched instruction
// fields; IR_WRITE/fetch PC_WRITE follow I_READY and the branch PC_WRITE
// follows ZERO within the cycle.
module multicycle_controller
  import cu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  multicycle_controller_if.master bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [FN_W-1:0]    fn_q, fn_d;
  logic               err_q, err_d;

  instr_class_t       cls;
  logic               limit_hit_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               take_branch_c;

  cu_class_decode u_class_decode (
    .opcode_i (op_q),
    .funct_i  (fn_q),
    .cls_o    (cls)
  );

  // Watchdog compare; a zero limit disables the fault path entirely.
  assign limit_hit_c = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT));
  // Saturate so a disabled watchdog never wraps back through the limit.
  assign cnt_inc_c   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  // BEQ (0x04) and BNE (0x05) differ only in opcode bit 0.
  assign take_branch_c = cls.is_branch && (op_q[0] ? !bus.ZERO : bus.ZERO);

  // Next-state, watchdog counter and instruction-field latch.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = '0;
    op_d    = op_q;
    fn_d    = fn_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (bus.I_READY) begin
          state_d = S_DECODE;
          op_d    = bus.OPCODE;
          fn_d    = bus.FUNCT;
        end else if (limit_hit_c) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (cls.is_branch || cls.is_jr) begin
          state_d = S_FETCH;
        end else if (cls.is_load || cls.is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.M_READY) begin
          state_d = cls.is_load ? S_WB : S_FETCH;
        end else if (limit_hit_c) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath-independent registers.
  always_ff @(posedge CLK or negedge RST_N) begin : regs
    if (!RST_N) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      fn_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      err_q   <= err_d;
    end
  end

  // Strobe decode; gated by RST_N so nothing is driven while reset is low.
  always_comb begin : out_decode
    bus.I_REQ    = 1'b0;
    bus.IR_WRITE = 1'b0;
    bus.PC_WRITE = 1'b0;
    bus.PC_SRC   = PC_PLUS4;
    bus.RG_READ  = 1'b0;
    bus.RG_WRITE = 1'b0;
    bus.RG_DST   = 1'b0;
    bus.ALU_EN   = 1'b0;
    bus.BRANCH   = 1'b0;
    bus.M_READ   = 1'b0;
    bus.M_WRITE  = 1'b0;
    bus.ERR      = 1'b0;
    if (RST_N) begin
      bus.ERR = err_q;
      case (state_q)
        S_FETCH: begin
          bus.I_REQ = 1'b1;
          if (bus.I_READY) begin
            bus.IR_WRITE = 1'b1;
            bus.PC_WRITE = 1'b1;
            bus.PC_SRC   = PC_PLUS4;
          end
        end
        S_DECODE: bus.RG_READ = cls.reads_reg;
        S_EXEC: begin
          bus.ALU_EN = 1'b1;
          bus.BRANCH = cls.is_branch;
          if (take_branch_c) begin
            bus.PC_WRITE = 1'b1;
            bus.PC_SRC   = PC_BRANCH;
          end else if (cls.is_jr) begin
            bus.PC_WRITE = 1'b1;
            bus.PC_SRC   = PC_REG;
          end
        end
        S_MEM: begin
          // Load and store are mutually exclusive classes.
          bus.M_READ  = cls.is_load;
          bus.M_WRITE = cls.is_store;
        end
        S_WB: begin
          bus.RG_WRITE = cls.writes_reg;
          bus.RG_DST   = cls.is_rtype;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (WAIT_LIMIT=4). Inputs change just
// after the falling edge and the strobe vector is sampled 1 time unit later.
module tb_multicycle_controller;

  localparam int unsigned WL = 4;
  localparam int unsigned CW = 3;

  // Strobe vector bit positions:
  // {I_REQ, IR_WRITE, PC_WRITE, PC_SRC[1:0], RG_READ, RG_WRITE, RG_DST,
  //  ALU_EN, BRANCH, M_READ, M_WRITE, ERR}
  localparam logic [12:0] NONE   = 13'h0000;
  localparam logic [12:0] IREQ   = 13'h1000;
  localparam logic [12:0] IRW    = 13'h0800;
  localparam logic [12:0] PCW    = 13'h0400;
  localparam logic [12:0] SRC_RG = 13'h0200;
  localparam logic [12:0] SRC_BR = 13'h0100;
  localparam logic [12:0] RGR    = 13'h0080;
  localparam logic [12:0] RGW    = 13'h0040;
  localparam logic [12:0] DST    = 13'h0020;
  localparam logic [12:0] ALU    = 13'h0010;
  localparam logic [12:0] BR     = 13'h0008;
  localparam logic [12:0] MR     = 13'h0004;
  localparam logic [12:0] MW     = 13'h0002;
  localparam logic [12:0] ERRB   = 13'h0001;
  localparam logic [12:0] FET    = IREQ | IRW | PCW;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  int          checks   = 0;
  int          failures = 0;
  logic [12:0] got;

  always #5 CLK = ~CLK;

  multicycle_controller_if bus ();

  multicycle_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  function automatic logic [12:0] outs();
    return {bus.I_REQ, bus.IR_WRITE, bus.PC_WRITE, bus.PC_SRC, bus.RG_READ,
            bus.RG_WRITE, bus.RG_DST, bus.ALU_EN, bus.BRANCH, bus.M_READ,
            bus.M_WRITE, bus.ERR};
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic ir, input logic mr);
    @(negedge CLK);
    bus.OPCODE  = op;
    bus.FUNCT   = fn;
    bus.ZERO    = z;
    bus.I_READY = ir;
    bus.M_READY = mr;
    #1;
    got = outs();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    bus.I_READY = 1'b1;
    bus.M_READY = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== NONE) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, NONE); end
    @(negedge CLK);
    #1;
    got = outs();
    checks++;
    if (got !== NONE) begin failures++; $display("FAIL reset_hold2 got=%h exp=%h", got, NONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    bus.I_READY = 1'b0;
    bus.M_READY = 1'b0;
    #1;
    got = outs();
    checks++;
    if (got !== IREQ) begin failures++; $display("FAIL reset_release got=%h exp=%h", got, IREQ); end
  endtask

  // ADD; opcode/funct inputs are scrambled after fetch to prove they are latched.
  task automatic test_rtype();
    logic [12:0] exp [5];
    exp = '{FET, RGR, ALU, RGW | DST, IREQ};
    for (int i = 0; i < 5; i++) begin
      step((i == 0) ? 6'h00 : 6'h3F, (i == 0) ? 6'h20 : 6'h08, 1'b0, i == 0, 1'b0);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL rtype_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  // LW with M_READY 3 cycles late; M_READY pulses in DECODE/EXEC are ignored.
  task automatic test_load();
    logic [12:0] exp [9];
    logic        mr  [9];
    exp = '{FET, RGR, ALU, MR, MR, MR, MR, RGW, IREQ};
    mr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(6'h23, 6'h00, 1'b0, i == 0, mr[i]);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL load_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4];
    logic        zs  [4];
    logic [12:0] ex  [4];
    logic [12:0] e;
    ops = '{6'h04, 6'h05, 6'h04, 6'h05};
    zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
    ex  = '{ALU | BR | PCW | SRC_BR, ALU | BR, ALU | BR, ALU | BR | PCW | SRC_BR};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        step(ops[k], 6'h00, zs[k], i == 0, 1'b0);
        case (i)
          0:       e = FET;
          1:       e = RGR;
          2:       e = ex[k];
          default: e = IREQ;
        endcase
        checks++;
        if (got !== e) begin failures++; $display("FAIL branch%0d_c%0d got=%h exp=%h", k, i, got, e); end
      end
    end
  endtask

  task automatic test_jr();
    logic [12:0] exp [4];
    exp = '{FET, RGR, ALU | PCW | SRC_RG, IREQ};
    for (int i = 0; i < 4; i++) begin
      step(6'h00, (i == 0) ? 6'h08 : 6'h20, 1'b0, i == 0, 1'b0);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL jr_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_noread();
    logic [12:0] exp [5];
    exp = '{FET, NONE, ALU, RGW, IREQ};
    for (int i = 0; i < 5; i++) begin
      step(6'h15, 6'h00, 1'b0, i == 0, 1'b0);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL noread_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_store();
    logic [12:0] exp [5];
    exp = '{FET, RGR, ALU, MW, IREQ};
    for (int i = 0; i < 5; i++) begin
      step(6'h28, 6'h00, 1'b0, i == 0, i == 3);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL store_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  // SW acknowledged in the very cycle the counter sits at the limit.
  task automatic test_ready_at_limit();
    logic [12:0] exp [9];
    exp = '{FET, RGR, ALU, MW, MW, MW, MW, MW, IREQ};
    for (int i = 0; i < 9; i++) begin
      step(6'h2B, 6'h00, 1'b0, i == 0, i == 7);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL rdy_limit_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  // SW never acknowledged: HALT with only ERR, READY in HALT ignored.
  task automatic test_watchdog();
    logic [12:0] exp [10];
    exp = '{FET, RGR, ALU, MW, MW, MW, MW, MW, ERRB, ERRB};
    for (int i = 0; i < 10; i++) begin
      step(6'h2B, 6'h00, 1'b0, (i == 0) || (i >= 8), i >= 8);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL mem_wdog_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
    @(negedge CLK);
    RST_N = 1'b0;
    bus.I_READY = 1'b0;
    bus.M_READY = 1'b0;
    #1;
    got = outs();
    checks++;
    if (got !== NONE) begin failures++; $display("FAIL wdog_rst_low got=%h exp=%h", got, NONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== IREQ) begin failures++; $display("FAIL wdog_rst_release got=%h exp=%h", got, IREQ); end
  endtask

  task automatic test_reset_mid_mem();
    logic [12:0] exp [4];
    exp = '{FET, RGR, ALU, MW};
    for (int i = 0; i < 4; i++) begin
      step(6'h2B, 6'h00, 1'b0, i == 0, 1'b0);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL midmem_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
    #2;
    RST_N = 1'b0;
    #1;
    got = outs();
    checks++;
    if (got !== NONE) begin failures++; $display("FAIL midmem_async got=%h exp=%h", got, NONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    got = outs();
    checks++;
    if (got !== IREQ) begin failures++; $display("FAIL midmem_release got=%h exp=%h", got, IREQ); end
    step(6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== FET) begin failures++; $display("FAIL midmem_refetch got=%h exp=%h", got, FET); end
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== RGR) begin failures++; $display("FAIL midmem_decode got=%h exp=%h", got, RGR); end
  endtask

  // Instruction memory never answers: fault out of FETCH.
  task automatic test_fetch_watchdog();
    logic [12:0] exp [6];
    exp = '{IREQ, IREQ, IREQ, IREQ, ERRB, ERRB};
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    bus.I_READY = 1'b0;
    bus.M_READY = 1'b0;
    #1;
    got = outs();
    checks++;
    if (got !== IREQ) begin failures++; $display("FAIL fwdog_release got=%h exp=%h", got, IREQ); end
    for (int i = 0; i < 6; i++) begin
      step(6'h00, 6'h20, 1'b0, i == 5, 1'b0);
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL fetch_wdog_c%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  initial begin
    bus.OPCODE  = 6'h00;
    bus.FUNCT   = 6'h00;
    bus.ZERO    = 1'b0;
    bus.I_READY = 1'b0;
    bus.M_READY = 1'b0;
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_jr();
    test_noread();
    test_store();
    test_ready_at_limit();
    test_watchdog();
    test_reset_mid_mem();
    test_fetch_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
